// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signal bundle for uart_tx_arbiter
// last_i exists only when UART_ARB_BURST_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_i;
  logic [8*N_REQ-1:0] data_i;
  logic [N_REQ-1:0]   psel_i;
`ifdef UART_ARB_BURST_EN
  logic [N_REQ-1:0]   last_i;
`endif
  logic [N_REQ-1:0]   ack_o;
  logic [N_REQ-1:0]   gnt_o;
  logic               busy_o;
  logic               err_o;
  logic               tx_st_o;
  logic [7:0]         tx_data_o;
  logic               tx_psel_o;
  logic               tx_eot_i;

`ifdef UART_ARB_BURST_EN
  modport slave (
    input  req_i, data_i, psel_i, last_i, tx_eot_i,
    output ack_o, gnt_o, busy_o, err_o, tx_st_o, tx_data_o, tx_psel_o
  );
  modport master (
    output req_i, data_i, psel_i, last_i, tx_eot_i,
    input  ack_o, gnt_o, busy_o, err_o, tx_st_o, tx_data_o, tx_psel_o
  );
`else
  modport slave (
    input  req_i, data_i, psel_i, tx_eot_i,
    output ack_o, gnt_o, busy_o, err_o, tx_st_o, tx_data_o, tx_psel_o
  );
  modport master (
    output req_i, data_i, psel_i, tx_eot_i,
    input  ack_o, gnt_o, busy_o, err_o, tx_st_o, tx_data_o, tx_psel_o
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N_REQ producers
// Define UART_ARB_BURST_EN to let a requester keep ownership until it flags last_i.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TO_CYCLES = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TO_CYCLES);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RELEASE
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     owner_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  ack_q;
  logic              err_q;
  logic              busy_q;
  logic              tx_st_q;
  logic [7:0]        tx_data_q;
  logic              tx_psel_q;
`ifdef UART_ARB_BURST_EN
  logic              lock_q;
`endif

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;

  function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] k);
    return (k == IW'(N_REQ - 1)) ? '0 : k + IW'(1);
  endfunction

  // Scan from ptr upward with wrap; a held burst lock overrides the scan.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % N_REQ);
      if (!win_found && bus.req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef UART_ARB_BURST_EN
    if (lock_q && bus.req_i[owner_q]) begin
      win_found = 1'b1;
      win_idx   = owner_q;
    end
`endif
  end

  assign cnt_d = cnt_q + CW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_st_q   <= 1'b0;
      tx_data_q <= 8'h00;
      tx_psel_q <= 1'b0;
`ifdef UART_ARB_BURST_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      tx_st_q <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef UART_ARB_BURST_EN
          if (lock_q && !bus.req_i[owner_q]) lock_q <= 1'b0;
`endif
          // A busy transmitter (eot low) blocks any new grant.
          if (win_found && bus.tx_eot_i) begin
            gnt_q     <= ONE_HOT0 << win_idx;
            owner_q   <= win_idx;
            tx_data_q <= bus.data_i[{win_idx, 3'b000} +: 8];
            tx_psel_q <= bus.psel_i[win_idx];
            tx_st_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_START;
`ifdef UART_ARB_BURST_EN
            lock_q    <= 1'b0;
`endif
          end
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!bus.tx_eot_i) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_d == CW'(TO_CYCLES - 1)) begin
            err_q   <= 1'b1;
            gnt_q   <= '0;
            ptr_q   <= nxt_idx(owner_q);
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`ifdef UART_ARB_BURST_EN
            lock_q  <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_DONE: begin
          // Frame length depends on baud rate, so no timeout here.
          if (bus.tx_eot_i) begin
            ack_q   <= gnt_q;
            gnt_q   <= '0;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
`ifdef UART_ARB_BURST_EN
          if (!bus.last_i[owner_q]) begin
            lock_q <= 1'b1;
          end else begin
            lock_q <= 1'b0;
            ptr_q  <= nxt_idx(owner_q);
          end
`else
          ptr_q   <= nxt_idx(owner_q);
`endif
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o     = ack_q;
  assign bus.gnt_o     = gnt_q;
  assign bus.busy_o    = busy_q;
  assign bus.err_o     = err_q;
  assign bus.tx_st_o   = tx_st_q;
  assign bus.tx_data_o = tx_data_q;
  assign bus.tx_psel_o = tx_psel_q;
endmodule
